uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 133 +++++++++++++
 tb/tb_uart_rx.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling, glitch reject and frame-error pulse
module uart_rx #(
  parameter int c_CYCLES_PER_BIT = 434
) (
  input  logic       i_CLK,
  input  logic       i_RST_N,
  input  logic       i_SERIAL_DATA,
  output logic [7:0] o_PARALLEL_DATA,
  output logic       o_RX_DV,
  output logic       o_RX_ACTIVE,
  output logic       o_FRAME_ERR
);

  localparam int CW = (c_CYCLES_PER_BIT > 1) ? $clog2(c_CYCLES_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(c_CYCLES_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'((c_CYCLES_PER_BIT - 1) / 2);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_STOP    = 3'd3;
  localparam logic [2:0] S_CLEANUP = 3'd4;

  logic          meta_q, rx_s_q;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          dv_q, dv_d;
  logic          ferr_q, ferr_d;

  // Synchronizer flops reset high so an idle line never looks like a start edge.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      meta_q <= 1'b1;
      rx_s_q <= 1'b1;
    end else begin
      meta_q <= i_SERIAL_DATA;
      rx_s_q <= meta_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s_q;
          if (idx_q == 3'd7) begin
            idx_d   = '0;
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = S_CLEANUP;
          if (rx_s_q) begin
            data_d = shift_q;
            dv_d   = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_CLEANUP: begin
        // Hold here through a break so a stuck-low line cannot start a new frame.
        cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      dv_q    <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      ferr_q  <= ferr_d;
    end
  end

  assign o_PARALLEL_DATA = data_q;
  assign o_RX_DV         = dv_q;
  assign o_FRAME_ERR     = ferr_q;
  assign o_RX_ACTIVE     = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed frames against a frame-level reference of the UART receiver
module tb_uart_rx;

  localparam int C = 16;
  localparam int H = (C - 1) / 2;
  localparam int NOM = H + 9 * C;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
    int         fall;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       line;
  logic [7:0] pdata;
  logic       rx_dv;
  logic       rx_active;
  logic       frame_err;

  int         cyc;
  int         n_checks;
  int         n_fail;
  int         dv_cnt;
  int         ferr_cnt;
  int         last_dv_cyc;
  int         last_fall;
  int         win_lo;
  int         win_hi;
  logic [7:0] model_data;
  exp_t       q[$];
  exp_t       ev;
  logic [7:0] seen[$];

  uart_rx #(.c_CYCLES_PER_BIT(C)) dut (
    .i_CLK           (clk),
    .i_RST_N         (rst_n),
    .i_SERIAL_DATA   (line),
    .o_PARALLEL_DATA (pdata),
    .o_RX_DV         (rx_dv),
    .o_RX_ACTIVE     (rx_active),
    .o_FRAME_ERR     (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected range %0d..%0d at cycle %0d", name, act, lo, hi, cyc);
    end
  endtask

  // Drives one frame starting just after a rising edge; abort_bit >= 0 stops mid data bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_val, input int hold_low,
                            input int abort_bit);
    exp_t e;
    if (abort_bit < 0) begin
      e.is_err = !stop_val;
      e.data   = b;
      e.fall   = cyc;
      q.push_back(e);
    end
    last_fall = cyc;
    win_lo    = cyc + 6;
    win_hi    = cyc + NOM;
    line = 1'b0;
    repeat (C) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      line = b[i];
      if (i == abort_bit) begin
        repeat (C / 2) @(posedge clk);
        #1;
        return;
      end
      repeat (C) @(posedge clk);
      #1;
    end
    line = stop_val;
    repeat (C) @(posedge clk);
    #1;
    if (!stop_val) begin
      repeat (hold_low) @(posedge clk);
      #1;
      chk("no_retrigger_while_low", int'(rx_active), 0);
      line = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_pdata", int'(pdata), 0);
      chk("reset_dv", int'(rx_dv), 0);
      chk("reset_active", int'(rx_active), 0);
      chk("reset_ferr", int'(frame_err), 0);
    end else begin
      chk("dv_ferr_exclusive", int'(rx_dv & frame_err), 0);
      if (rx_dv || frame_err) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse: dv=%0d ferr=%0d expected no pulse at cycle %0d", rx_dv, frame_err, cyc);
        end else begin
          ev = q.pop_front();
          chk("pulse_is_frame_err", int'(frame_err), int'(ev.is_err));
          chk_rng("pulse_latency_k", cyc - ev.fall - NOM, 2, 5);
          if (!ev.is_err) model_data = ev.data;
        end
        if (rx_dv) begin
          dv_cnt++;
          last_dv_cyc = cyc;
          seen.push_back(pdata);
        end
        if (frame_err) ferr_cnt++;
      end
      chk("parallel_data", int'(pdata), int'(model_data));
      if (cyc >= win_lo && cyc <= win_hi) chk("active_in_frame", int'(rx_active), 1);
    end
  end

  initial begin
    int d0, f0;
    n_checks = 0;
    n_fail = 0;
    dv_cnt = 0;
    ferr_cnt = 0;
    last_dv_cyc = 0;
    last_fall = 0;
    win_lo = 1;
    win_hi = 0;
    model_data = 8'h00;
    rst_n = 1'b0;
    line = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("por_pdata", int'(pdata), 8'h00);
    chk("por_active", int'(rx_active), 0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    d0 = dv_cnt; f0 = ferr_cnt;
    send_frame(8'hA5, 1'b1, 0, -1);
    repeat (C) @(posedge clk);
    #1;
    chk("a5_dv_count", dv_cnt - d0, 1);
    chk("a5_ferr_count", ferr_cnt - f0, 0);
    chk("a5_data", int'(pdata), 8'hA5);
    chk("a5_idle_active", int'(rx_active), 0);

    d0 = dv_cnt; f0 = ferr_cnt;
    line = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    line = 1'b1;
    repeat (2 * C) @(posedge clk);
    #1;
    chk("glitch_dv_count", dv_cnt - d0, 0);
    chk("glitch_ferr_count", ferr_cnt - f0, 0);
    chk("glitch_active", int'(rx_active), 0);

    d0 = dv_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, 40, -1);
    repeat (C) @(posedge clk);
    #1;
    chk("ferr_count", ferr_cnt - f0, 1);
    chk("ferr_dv_count", dv_cnt - d0, 0);
    chk("ferr_data_kept", int'(pdata), 8'hA5);

    d0 = dv_cnt;
    send_frame(8'h00, 1'b1, 0, -1);
    send_frame(8'hFF, 1'b1, 0, -1);
    repeat (C) @(posedge clk);
    #1;
    chk("b2b_dv_count", dv_cnt - d0, 2);
    chk("b2b_first", int'(seen[seen.size()-2]), 8'h00);
    chk("b2b_second", int'(seen[seen.size()-1]), 8'hFF);

    d0 = dv_cnt; f0 = ferr_cnt;
    send_frame(8'h77, 1'b1, 0, 4);
    chk("abort_active_before_reset", int'(rx_active), 1);
    #3;
    q.delete();
    model_data = 8'h00;
    win_lo = 1;
    win_hi = 0;
    rst_n = 1'b0;
    #1;
    chk("async_reset_pdata", int'(pdata), 8'h00);
    chk("async_reset_active", int'(rx_active), 0);
    line = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_no_pulse", (dv_cnt - d0) + (ferr_cnt - f0), 0);
    send_frame(8'h5A, 1'b1, 0, -1);
    repeat (C) @(posedge clk);
    #1;
    chk("post_reset_dv_count", dv_cnt - d0, 1);
    chk("post_reset_data", int'(pdata), 8'h5A);

    send_frame(8'h81, 1'b1, 0, -1);
    repeat (C) @(posedge clk);
    #1;
    chk("x81_data", int'(pdata), 8'h81);
    chk_rng("x81_latency", last_dv_cyc - last_fall, 7 + 144 + 2, 7 + 144 + 5);

    chk("pending_events", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
